lifo_stack: RTL and testbench
=============================

Name: lifo_stack

Overview:
Parametrised LIFO operand stack for the RPN evaluator. It is the successor to the fixed 32x16 stack and adds:
- configurable width and depth;
- correct full/empty handshakes;
- a same-cycle push+pop "replace" operation;
- a second-of-stack read port, so binary operators see both operands;
- synchronous clear, occupancy count and sticky error flags.
It sits between the token decoder (pusher) and the ALU (popper).

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 16, number of entries (>=2, any integer, not required to be a power of two)
CW, $clog2(DEPTH+1), occupancy count width (derived, not overridden)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
CLR  in  1  synchronous clear; empties the stack and clears error flags
PUSH_STB  in  1  push request
PUSH_DAT  in  WIDTH  push data
PUSH_ACK  out  1  push accepted this cycle
POP_STB  out  1  top-of-stack valid (stack non-empty)
POP_DAT  out  WIDTH  top-of-stack entry
POP_ACK  in  1  consumer takes the top entry this cycle
NOS_VLD  out  1  second entry valid (count>=2)
NOS_DAT  out  WIDTH  next-of-stack entry (entry below top)
COUNT  out  CW  current occupancy, 0..DEPTH
FULL  out  1  COUNT==DEPTH
EMPTY  out  1  COUNT==0
OVF_ERR  out  1  sticky: push request refused because stack was full
UNF_ERR  out  1  sticky: POP_ACK asserted while stack empty
HWM  out  CW  high-water mark (see Optional Feature)

Behaviour:
- Reset (RST high, async): COUNT=0, EMPTY=1, FULL=0, POP_STB=0, NOS_VLD=0, OVF_ERR=0, UNF_ERR=0, HWM=0. Storage contents are undefined and are not reset.
- Storage: the stack pointer equals COUNT. Entry i is stored at index i. The top is at COUNT-1 and the next-of-stack is at COUNT-2.
- POP_DAT and NOS_DAT are combinational reads of the current state, with zero latency.
- When not valid, POP_DAT and NOS_DAT drive don't-care; the bench must not check them.
- POP_STB = ~EMPTY. NOS_VLD = (COUNT>=2).
- pop_do = POP_ACK & POP_STB.
- PUSH_ACK = PUSH_STB & (~FULL | pop_do). Combinational.
- Operations per rising edge, evaluated in priority order:
  - CLR: COUNT<=0 and both error flags cleared. A push or pop in the same cycle is ignored, and PUSH_ACK is forced to 0 while CLR is high.
  - REPLACE (PUSH_ACK & pop_do): the entry at COUNT-1 is overwritten with PUSH_DAT; COUNT is unchanged. This is legal when full.
  - PUSH (PUSH_ACK only): mem[COUNT]<=PUSH_DAT; COUNT<=COUNT+1.
  - POP (pop_do only): COUNT<=COUNT-1. Data is not erased.
  - Otherwise the state is held.
- Errors (sticky until CLR or RST):
  - OVF_ERR is set when PUSH_STB & FULL & ~pop_do & ~CLR.
  - UNF_ERR is set when POP_ACK & EMPTY & ~CLR.
  - The offending request has no other effect.
- Boundaries:
  - COUNT never wraps.
  - A push when full without a pop is refused.
  - A pop when empty is ignored.
  - PUSH_STB together with POP_ACK when empty is a plain push, and UNF_ERR is set.
- Reset asserted mid-operation aborts immediately, with no partial write committed.

Optional Feature:
Macro LIFO_STACK_HWM_EN.
- When defined: HWM is a register tracking the maximum COUNT reached since the last RST or CLR. It updates on the same edge as COUNT, to max(HWM, next COUNT).
- When undefined: HWM is tied to 0 and no register is synthesised.
- The port list is identical in both cases.

Decomposition:
Shared package lifo_stack_pkg contains:
- the op enum: OP_NONE, OP_PUSH, OP_POP, OP_REPLACE, OP_CLEAR;
- a helper function cw(depth) returning $clog2(depth+1).

One sub-module, lifo_stack_mem, holds the storage:
- DEPTH x WIDTH register array;
- one synchronous write port;
- two asynchronous read ports (top and next-of-stack).

Control, counters and flags live in lifo_stack.

Test Plan:
1. WIDTH=32, DEPTH=4. Push 0x11, 0x22, 0x33 -> COUNT=3, POP_DAT=0x33, NOS_DAT=0x22, NOS_VLD=1. Then three POP_ACK cycles -> POP_DAT reads 0x33, 0x22, 0x11, then EMPTY=1.
2. Fill DEPTH=4 with 1..4, then push 5 -> PUSH_ACK=0, COUNT=4, OVF_ERR=1, top still 4. Push 5 with POP_ACK in the same cycle -> REPLACE: COUNT=4, top=5, NOS=3.
3. Empty stack, POP_ACK=1 -> UNF_ERR=1, COUNT=0. With PUSH_STB=1 and PUSH_DAT=0xAA in the same cycle -> COUNT=1, top=0xAA.
4. Stack with COUNT=3 and both errors set, pulse CLR together with PUSH_STB -> PUSH_ACK=0, COUNT=0, OVF_ERR=0, UNF_ERR=0, HWM=0.
5. Assert RST asynchronously mid-push (between edges) -> all outputs at reset values immediately, with no write committed afterwards.
6. With LIFO_STACK_HWM_EN, DEPTH=5: push 3, pop 2, push 1 -> HWM=3, COUNT=2. Without the macro, the same sequence gives HWM=0 throughout.

Source files
------------

// File: rtl/lifo_stack_pkg.sv
// Shared types and helpers for the RPN operand stack.
package lifo_stack_pkg;

    // Operation committed on a clock edge, in priority order.
    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_CLEAR
    } op_e;

    // Width needed to hold an occupancy count of 0..depth.
    function automatic int unsigned cw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// Stack storage: DEPTH x WIDTH registers, one synchronous write port and
// two asynchronous read ports (top and next-of-stack). Not reset.
module lifo_stack_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    top_addr,
    output logic [WIDTH-1:0] top_dat,
    input  logic [AW-1:0]    nos_addr,
    output logic [WIDTH-1:0] nos_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; the controller only ever presents in-range addresses.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports; an address beyond DEPTH (only seen when the entry is not
    // valid, e.g. count-1 with an empty stack) returns zero instead of X.
    always_comb begin
        top_dat = '0;
        nos_dat = '0;
        if (32'(top_addr) < DEPTH) begin
            top_dat = mem[top_addr];
        end
        if (32'(nos_addr) < DEPTH) begin
            nos_dat = mem[nos_addr];
        end
    end

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO operand stack between the token decoder and the ALU.
// Supports push, pop, same-cycle replace, a next-of-stack read port,
// synchronous clear, occupancy count and sticky overflow/underflow flags.
// Optional macro LIFO_STACK_HWM_EN enables the high-water-mark register;
// without it HWM is tied to zero.
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    // Derived from DEPTH; do not override.
    parameter int unsigned CW    = cw(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             PUSH_STB,
    input  logic [WIDTH-1:0] PUSH_DAT,
    output logic             PUSH_ACK,
    output logic             POP_STB,
    output logic [WIDTH-1:0] POP_DAT,
    input  logic             POP_ACK,
    output logic             NOS_VLD,
    output logic [WIDTH-1:0] NOS_DAT,
    output logic [CW-1:0]    COUNT,
    output logic             FULL,
    output logic             EMPTY,
    output logic             OVF_ERR,
    output logic             UNF_ERR,
    output logic [CW-1:0]    HWM
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          full, empty, pop_do, push_ack;
    logic          mem_we;
    logic [AW-1:0] mem_waddr, top_addr, nos_addr;
    op_e           op;

    // Status and handshakes derived from the current occupancy.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        pop_do   = POP_ACK & ~empty;
        // Refuse pushes during clear or reset so nothing is acknowledged
        // that will not be committed.
        push_ack = PUSH_STB & ~CLR & ~RST & (~full | pop_do);
    end

    // Decode the operation for this edge in priority order.
    always_comb begin
        op = OP_NONE;
        if (CLR) begin
            op = OP_CLEAR;
        end else if (push_ack && pop_do) begin
            op = OP_REPLACE;
        end else if (push_ack) begin
            op = OP_PUSH;
        end else if (pop_do) begin
            op = OP_POP;
        end
    end

    // Next count and sticky error flags.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q | (PUSH_STB & full & ~pop_do);
        unf_d   = unf_q | (POP_ACK & empty);
        unique case (op)
            OP_CLEAR: begin
                count_d = '0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end
            OP_PUSH: count_d = count_q + CW'(1);
            OP_POP:  count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Occupancy and error state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage addressing: replace overwrites the top, push writes above it.
    always_comb begin
        mem_we    = ((op == OP_PUSH) || (op == OP_REPLACE)) & ~RST;
        mem_waddr = (op == OP_REPLACE) ? AW'(count_q - CW'(1)) : AW'(count_q);
        top_addr  = AW'(count_q - CW'(1));
        nos_addr  = AW'(count_q - CW'(2));
    end

    lifo_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk      (CLK),
        .we       (mem_we),
        .waddr    (mem_waddr),
        .wdata    (PUSH_DAT),
        .top_addr (top_addr),
        .top_dat  (POP_DAT),
        .nos_addr (nos_addr),
        .nos_dat  (NOS_DAT)
    );

`ifdef LIFO_STACK_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d;

    // Track the largest occupancy since the last reset or clear.
    always_comb begin
        hwm_d = hwm_q;
        if (op == OP_CLEAR) begin
            hwm_d = '0;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    // High-water-mark register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign HWM = hwm_q;
`else
    assign HWM = '0;
`endif

    assign PUSH_ACK = push_ack;
    assign POP_STB  = ~empty;
    assign NOS_VLD  = (count_q >= CW'(2));
    assign COUNT    = count_q;
    assign FULL     = full;
    assign EMPTY    = empty;
    assign OVF_ERR  = ovf_q;
    assign UNF_ERR  = unf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: a DEPTH=4 instance for the main
// scenarios and a DEPTH=5 instance for the high-water-mark sequence.
module tb_lifo_stack;

    localparam int unsigned W = 32;
`ifdef LIFO_STACK_HWM_EN
    localparam bit HwmEn = 1'b1;
`else
    localparam bit HwmEn = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;

    logic         clr4 = 1'b0, push_stb4 = 1'b0, pop_ack4 = 1'b0;
    logic [W-1:0] push_dat4 = '0;
    logic         push_ack4, pop_stb4, nos_vld4, full4, empty4, ovf4, unf4;
    logic [W-1:0] pop_dat4, nos_dat4;
    logic [2:0]   count4, hwm4;

    logic         clr5 = 1'b0, push_stb5 = 1'b0, pop_ack5 = 1'b0;
    logic [W-1:0] push_dat5 = '0;
    logic         push_ack5, pop_stb5, nos_vld5, full5, empty5, ovf5, unf5;
    logic [W-1:0] pop_dat5, nos_dat5;
    logic [2:0]   count5, hwm5;

    int checks   = 0;
    int failures = 0;

    // Reference model of the DEPTH=4 stack and the pop scoreboard.
    logic [W-1:0] model[$];
    logic [W-1:0] sb[$];
    bit           ovf_m = 1'b0, unf_m = 1'b0;
    int           hwm_m = 0;

    always #5 CLK = ~CLK;

    lifo_stack #(.WIDTH(W), .DEPTH(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .CLR(clr4),
        .PUSH_STB(push_stb4), .PUSH_DAT(push_dat4), .PUSH_ACK(push_ack4),
        .POP_STB(pop_stb4), .POP_DAT(pop_dat4), .POP_ACK(pop_ack4),
        .NOS_VLD(nos_vld4), .NOS_DAT(nos_dat4), .COUNT(count4),
        .FULL(full4), .EMPTY(empty4), .OVF_ERR(ovf4), .UNF_ERR(unf4), .HWM(hwm4)
    );

    lifo_stack #(.WIDTH(W), .DEPTH(5)) u_dut5 (
        .CLK(CLK), .RST(RST), .CLR(clr5),
        .PUSH_STB(push_stb5), .PUSH_DAT(push_dat5), .PUSH_ACK(push_ack5),
        .POP_STB(pop_stb5), .POP_DAT(pop_dat5), .POP_ACK(pop_ack5),
        .NOS_VLD(nos_vld5), .NOS_DAT(nos_dat5), .COUNT(count5),
        .FULL(full5), .EMPTY(empty5), .OVF_ERR(ovf5), .UNF_ERR(unf5), .HWM(hwm5)
    );

    function automatic logic [2:0] exp_hwm();
        return HwmEn ? 3'(hwm_m) : 3'd0;
    endfunction

    // One clock of push/pop on the DEPTH=4 instance; entered at posedge+1.
    task automatic do_cycle(input bit push, input logic [W-1:0] dat, input bit pop,
                            input string name);
        int           sz;
        bit           full_m, pop_do, ack;
        logic [W-1:0] exp;
        push_stb4 = push;
        push_dat4 = dat;
        pop_ack4  = pop;
        #1;
        sz     = model.size();
        full_m = (sz == 4);
        pop_do = pop && (sz > 0);
        ack    = push && (!full_m || pop_do);
        checks++;
        if (push_ack4 !== ack) begin
            failures++;
            $display("FAIL %s push_ack: got %b expected %b", name, push_ack4, ack);
        end
        if (pop_do) begin
            sb.push_back(model[sz-1]);
            exp = sb.pop_front();
            checks++;
            if (pop_dat4 !== exp) begin
                failures++;
                $display("FAIL %s pop_dat: got %0h expected %0h", name, pop_dat4, exp);
            end
        end
        if (push && full_m && !pop_do) ovf_m = 1'b1;
        if (pop && sz == 0) unf_m = 1'b1;
        if (ack && pop_do) model[sz-1] = dat;
        else if (ack) model.push_back(dat);
        else if (pop_do) model.delete(sz-1);
        if (model.size() > hwm_m) hwm_m = model.size();
        @(posedge CLK);
        #1;
        push_stb4 = 1'b0;
        pop_ack4  = 1'b0;
    endtask

    // Synchronous clear, optionally with a competing push.
    task automatic do_clear(input bit push, input string name);
        clr4      = 1'b1;
        push_stb4 = push;
        push_dat4 = 32'hdead_beef;
        #1;
        checks++;
        if (push_ack4 !== 1'b0) begin
            failures++;
            $display("FAIL %s push_ack_clr: got %b expected 0", name, push_ack4);
        end
        @(posedge CLK);
        #1;
        clr4      = 1'b0;
        push_stb4 = 1'b0;
        model.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        hwm_m = 0;
    endtask

    task automatic test_reset();
        #1;
        checks += 10;
        if (count4 !== 3'd0) begin failures++; $display("FAIL rst_count: got %0d expected 0", count4); end
        if (empty4 !== 1'b1) begin failures++; $display("FAIL rst_empty: got %b expected 1", empty4); end
        if (full4 !== 1'b0) begin failures++; $display("FAIL rst_full: got %b expected 0", full4); end
        if (pop_stb4 !== 1'b0) begin failures++; $display("FAIL rst_pop_stb: got %b expected 0", pop_stb4); end
        if (nos_vld4 !== 1'b0) begin failures++; $display("FAIL rst_nos_vld: got %b expected 0", nos_vld4); end
        if (ovf4 !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b expected 0", ovf4); end
        if (unf4 !== 1'b0) begin failures++; $display("FAIL rst_unf: got %b expected 0", unf4); end
        if (hwm4 !== 3'd0) begin failures++; $display("FAIL rst_hwm: got %0d expected 0", hwm4); end
        if (count5 !== 3'd0) begin failures++; $display("FAIL rst_count5: got %0d expected 0", count5); end
        if (hwm5 !== 3'd0) begin failures++; $display("FAIL rst_hwm5: got %0d expected 0", hwm5); end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_push_pop();
        do_cycle(1'b1, 32'h11, 1'b0, "pp_push");
        do_cycle(1'b1, 32'h22, 1'b0, "pp_push");
        do_cycle(1'b1, 32'h33, 1'b0, "pp_push");
        checks += 5;
        if (count4 !== 3'd3) begin failures++; $display("FAIL pp_count: got %0d expected 3", count4); end
        if (pop_dat4 !== 32'h33) begin failures++; $display("FAIL pp_top: got %0h expected 33", pop_dat4); end
        if (nos_dat4 !== 32'h22) begin failures++; $display("FAIL pp_nos: got %0h expected 22", nos_dat4); end
        if (nos_vld4 !== 1'b1) begin failures++; $display("FAIL pp_nos_vld: got %b expected 1", nos_vld4); end
        if (hwm4 !== exp_hwm()) begin failures++; $display("FAIL pp_hwm: got %0d expected %0d", hwm4, exp_hwm()); end
        for (int i = 0; i < 3; i++) do_cycle(1'b0, '0, 1'b1, "pp_pop");
        checks += 2;
        if (empty4 !== 1'b1) begin failures++; $display("FAIL pp_empty: got %b expected 1", empty4); end
        if (pop_stb4 !== 1'b0) begin failures++; $display("FAIL pp_pop_stb: got %b expected 0", pop_stb4); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) do_cycle(1'b1, W'(i), 1'b0, "ovf_fill");
        checks++;
        if (full4 !== 1'b1) begin failures++; $display("FAIL ovf_full: got %b expected 1", full4); end
        do_cycle(1'b1, 32'h5, 1'b0, "ovf_push");
        checks += 3;
        if (count4 !== 3'd4) begin failures++; $display("FAIL ovf_count: got %0d expected 4", count4); end
        if (ovf4 !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b expected 1", ovf4); end
        if (pop_dat4 !== 32'h4) begin failures++; $display("FAIL ovf_top: got %0h expected 4", pop_dat4); end
        do_cycle(1'b1, 32'h5, 1'b1, "ovf_replace");
        checks += 3;
        if (count4 !== 3'd4) begin failures++; $display("FAIL rep_count: got %0d expected 4", count4); end
        if (pop_dat4 !== 32'h5) begin failures++; $display("FAIL rep_top: got %0h expected 5", pop_dat4); end
        if (nos_dat4 !== 32'h3) begin failures++; $display("FAIL rep_nos: got %0h expected 3", nos_dat4); end
    endtask

    task automatic test_underflow();
        do_clear(1'b0, "unf_clr");
        do_cycle(1'b0, '0, 1'b1, "unf_pop");
        checks += 3;
        if (unf4 !== 1'b1) begin failures++; $display("FAIL unf_flag: got %b expected 1", unf4); end
        if (count4 !== 3'd0) begin failures++; $display("FAIL unf_count: got %0d expected 0", count4); end
        if (ovf4 !== 1'b0) begin failures++; $display("FAIL unf_ovf: got %b expected 0", ovf4); end
        do_cycle(1'b1, 32'hAA, 1'b1, "unf_push_pop");
        checks += 2;
        if (count4 !== 3'd1) begin failures++; $display("FAIL unf_pp_count: got %0d expected 1", count4); end
        if (pop_dat4 !== 32'hAA) begin failures++; $display("FAIL unf_pp_top: got %0h expected aa", pop_dat4); end
    endtask

    task automatic test_clear();
        do_cycle(1'b1, 32'hB1, 1'b0, "clr_setup");
        do_cycle(1'b1, 32'hB2, 1'b0, "clr_setup");
        do_cycle(1'b1, 32'hB3, 1'b0, "clr_setup");
        do_cycle(1'b1, 32'hB4, 1'b0, "clr_setup");
        do_cycle(1'b0, '0, 1'b1, "clr_setup");
        checks += 3;
        if (count4 !== 3'd3) begin failures++; $display("FAIL clr_pre_count: got %0d expected 3", count4); end
        if (ovf4 !== 1'b1) begin failures++; $display("FAIL clr_pre_ovf: got %b expected 1", ovf4); end
        if (unf4 !== 1'b1) begin failures++; $display("FAIL clr_pre_unf: got %b expected 1", unf4); end
        do_clear(1'b1, "clr");
        checks += 5;
        if (count4 !== 3'd0) begin failures++; $display("FAIL clr_count: got %0d expected 0", count4); end
        if (ovf4 !== 1'b0) begin failures++; $display("FAIL clr_ovf: got %b expected 0", ovf4); end
        if (unf4 !== 1'b0) begin failures++; $display("FAIL clr_unf: got %b expected 0", unf4); end
        if (hwm4 !== 3'd0) begin failures++; $display("FAIL clr_hwm: got %0d expected 0", hwm4); end
        if (empty4 !== 1'b1) begin failures++; $display("FAIL clr_empty: got %b expected 1", empty4); end
    endtask

    task automatic test_async_reset();
        do_cycle(1'b1, 32'h55, 1'b0, "ar_setup");
        do_cycle(1'b1, 32'h66, 1'b0, "ar_setup");
        push_stb4 = 1'b1;
        push_dat4 = 32'h77;
        #2;
        RST = 1'b1;
        #1;
        checks += 6;
        if (count4 !== 3'd0) begin failures++; $display("FAIL ar_count: got %0d expected 0", count4); end
        if (empty4 !== 1'b1) begin failures++; $display("FAIL ar_empty: got %b expected 1", empty4); end
        if (pop_stb4 !== 1'b0) begin failures++; $display("FAIL ar_pop_stb: got %b expected 0", pop_stb4); end
        if (nos_vld4 !== 1'b0) begin failures++; $display("FAIL ar_nos_vld: got %b expected 0", nos_vld4); end
        if (full4 !== 1'b0) begin failures++; $display("FAIL ar_full: got %b expected 0", full4); end
        if (hwm4 !== 3'd0) begin failures++; $display("FAIL ar_hwm: got %0d expected 0", hwm4); end
        model.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        hwm_m = 0;
        @(posedge CLK);
        #1;
        checks++;
        if (count4 !== 3'd0) begin failures++; $display("FAIL ar_hold_count: got %0d expected 0", count4); end
        push_stb4 = 1'b0;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        do_cycle(1'b1, 32'h99, 1'b0, "ar_after");
        checks += 3;
        if (count4 !== 3'd1) begin failures++; $display("FAIL ar_after_count: got %0d expected 1", count4); end
        if (pop_dat4 !== 32'h99) begin failures++; $display("FAIL ar_after_top: got %0h expected 99", pop_dat4); end
        if (nos_vld4 !== 1'b0) begin failures++; $display("FAIL ar_after_nos_vld: got %b expected 0", nos_vld4); end
    endtask

    task automatic test_back_to_back();
        int           r, pct;
        bit           push, pop;
        logic [W-1:0] dat;
        for (int i = 0; i < 300; i++) begin
            pct  = (i < 100) ? 75 : ((i < 200) ? 25 : 50);
            r    = $urandom_range(0, 19);
            push = ($urandom_range(0, 99) < pct);
            pop  = ($urandom_range(0, 99) >= pct);
            if ($urandom_range(0, 3) == 0) pop = ~pop;
            dat  = $urandom;
            if (r == 0) do_clear(push, "b2b_clr");
            else do_cycle(push, dat, pop, "b2b");
            checks += 7;
            if (count4 !== 3'(model.size())) begin failures++; $display("FAIL b2b_count: got %0d expected %0d", count4, model.size()); end
            if (full4 !== (model.size() == 4)) begin failures++; $display("FAIL b2b_full: got %b expected %b", full4, model.size() == 4); end
            if (empty4 !== (model.size() == 0)) begin failures++; $display("FAIL b2b_empty: got %b expected %b", empty4, model.size() == 0); end
            if (nos_vld4 !== (model.size() >= 2)) begin failures++; $display("FAIL b2b_nos_vld: got %b expected %b", nos_vld4, model.size() >= 2); end
            if (ovf4 !== ovf_m) begin failures++; $display("FAIL b2b_ovf: got %b expected %b", ovf4, ovf_m); end
            if (unf4 !== unf_m) begin failures++; $display("FAIL b2b_unf: got %b expected %b", unf4, unf_m); end
            if (hwm4 !== exp_hwm()) begin failures++; $display("FAIL b2b_hwm: got %0d expected %0d", hwm4, exp_hwm()); end
            if (model.size() >= 1) begin
                checks++;
                if (pop_dat4 !== model[model.size()-1]) begin failures++; $display("FAIL b2b_top: got %0h expected %0h", pop_dat4, model[model.size()-1]); end
            end
            if (model.size() >= 2) begin
                checks++;
                if (nos_dat4 !== model[model.size()-2]) begin failures++; $display("FAIL b2b_nos: got %0h expected %0h", nos_dat4, model[model.size()-2]); end
            end
        end
    endtask

    // Push 3, pop 2, push 1 on the DEPTH=5 instance.
    task automatic test_hwm();
        int         cnt = 0;
        int         peak = 0;
        logic [2:0] hexp;
        for (int i = 0; i < 6; i++) begin
            push_stb5 = (i < 3) || (i == 5);
            pop_ack5  = (i == 3) || (i == 4);
            push_dat5 = W'(i + 1);
            @(posedge CLK);
            #1;
            push_stb5 = 1'b0;
            pop_ack5  = 1'b0;
            cnt  = push_stb5 ? cnt : cnt;
            cnt  = ((i < 3) || (i == 5)) ? cnt + 1 : cnt - 1;
            peak = (cnt > peak) ? cnt : peak;
            hexp = HwmEn ? 3'(peak) : 3'd0;
            checks += 2;
            if (count5 !== 3'(cnt)) begin failures++; $display("FAIL hwm_count step %0d: got %0d expected %0d", i, count5, cnt); end
            if (hwm5 !== hexp) begin failures++; $display("FAIL hwm_value step %0d: got %0d expected %0d", i, hwm5, hexp); end
        end
        checks++;
        if (pop_dat5 !== W'(6)) begin failures++; $display("FAIL hwm_top: got %0h expected 6", pop_dat5); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_clear();
        test_async_reset();
        test_back_to_back();
        test_hwm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
